slice_fault_scan_ctrl: RTL and testbench
========================================

# slice_fault_scan_ctrl

Sequencer that runs the one-slice stuck-at detection algorithm on a `mac_slice_faulty` instance. It drives two test patterns into the slice's `in_array`/`weight_array` ports and captures `product_array` after the slice latency. From the captures it builds per-cell SA0/SA1 fault maps and an optional fault count. It sits between the test host (start/done) and the MAC slice; the maps feed downstream fault-aware weight remapping.

## Interface
- `N`, 256: cells per slice; must match the slice.
- `MAC_LAT`, 1: clock cycles from pattern change to valid `product_array`; ≥1.
- `CHUNK`, 16: cells counted per cycle in COUNT; N must be a multiple of CHUNK.
- `clk` input 1: clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: single-cycle request to begin a scan.
- `in_array` output N: input pattern to the slice.
- `weight_array` output 4*N: weight pattern to the slice.
- `product_array` input 4*N: slice output.
- `busy` output 1: high from start acceptance until the DONE cycle inclusive.
- `done` output 1: one-cycle pulse; maps and count are valid from this cycle on.
- `sa0_map` output N: cell i stuck-at-0.
- `sa1_map` output N: cell i stuck-at-1.
- `fault_count` output $clog2(N+1): number of faulty cells.

## Operation
- States: IDLE, P0, C0, P1, C1, COUNT, DONE.
- IDLE: `in_array`/`weight_array` = 0; `start` accepted → clear maps/count, drive phase-0 pattern, go to P0.
- Phase 0 pattern: `in_array`=all 1s, weight nibbles = 4'h0. Expected product per cell 4'h0.
- P0: hold pattern for MAC_LAT cycles (wait counter), then C0.
- C0: sample `product_array`; `sa1_map[i]` = (nibble i != 4'h0). Drive phase-1 pattern (weights 4'hF, inputs all 1s), go to P1.
- P1: hold MAC_LAT cycles, then C1.
- C1: `sa0_map[i]` = (nibble i != 4'hF) AND NOT `sa1_map[i]`. SA1 takes precedence; a cell is never flagged in both maps. Patterns return to 0. Go to COUNT, or to DONE when the count is compiled out.
- COUNT: N/CHUNK cycles. Each cycle adds the popcount of the chunk's (sa0|sa1) bits to `fault_count`. Chunk index goes 0 upward and wraps to 0 on exit.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored; it is not queued.
- Maps and count hold their values after DONE until the next accepted `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `in_array`=0, `weight_array`=0, `sa0_map`=0, `sa1_map`=0, `fault_count`=0, state IDLE, counters 0.
- Reset asserted mid-scan aborts immediately. No `done` is produced and partial maps are discarded (zeroed).
- All outputs are registered.
- Patterns change on the edge that enters P0/P1. The product is sampled on the edge leaving C0/C1, i.e. MAC_LAT+1 edges after the pattern change.
- `done` rises at edge 2*MAC_LAT+3+N/CHUNK after the edge that sampled `start`:
  - with the count compiled in, 21 at defaults;
  - without it, 2*MAC_LAT+3 (5 at defaults).
- `start` asserted in the DONE cycle is ignored. `start` asserted in the following IDLE cycle is accepted.

## Configuration
- `SLICE_SCAN_FAULT_COUNT_EN` defined: COUNT state and chunk popcount logic are present; `fault_count` is valid at `done`.
- Not defined: COUNT is removed, C1 goes directly to DONE, and `fault_count` is tied to 0. The port list is unchanged.

## Structure
- Package `slice_scan_pkg` holds:
  - the state enum;
  - pattern constants (P0_WEIGHT=4'h0, P1_WEIGHT=4'hF, EXP0=4'h0, EXP1=4'hF);
  - a width function for `fault_count`.
- Sub-module `slice_popcount_chunk`: combinational CHUNK-bit popcount, instantiated once and muxed by chunk index.

## Test plan
- No faults (`sa0_cells`/`sa1_cells`=0 on the slice): start → `done` at edge 21; both maps 0; `fault_count`=0; patterns back to 0 after C1.
- `sa1_cells[3]`=1, `sa0_cells[200]`=1 → `sa1_map`=1<<3, `sa0_map`=1<<200, `fault_count`=2.
- Cell 7 with both SA1 and SA0 set → `sa1_map[7]`=1, `sa0_map[7]`=0, count 1.
- All 256 cells SA0 → `sa0_map` all 1s, `fault_count`=256 (chunk accumulation without overflow).
- `start` pulsed again during P1 and during DONE → ignored; exactly one `done`. Next `start` re-clears the maps.
- `rst_n` low during COUNT → all outputs 0 asynchronously, no `done`. Restart after release completes normally. Repeat the no-fault case with the macro undefined → `done` at edge 5.

Source files
------------

// File: rtl/slice_scan_pkg.sv
// Shared state encoding, test patterns and width helper for the slice stuck-at scan sequencer.
package slice_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_C0,
        S_P1,
        S_C1,
        S_COUNT,
        S_DONE
    } scan_state_t;

    localparam logic [3:0] P0_WEIGHT = 4'h0;
    localparam logic [3:0] P1_WEIGHT = 4'hF;
    localparam logic [3:0] EXP0      = 4'h0;
    localparam logic [3:0] EXP1      = 4'hF;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/slice_popcount_chunk.sv
// Combinational population count of one chunk of the per-cell fault vector.
module slice_popcount_chunk
    import slice_scan_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]              chunk_bits,
    output logic [count_width(W)-1:0] count
);

    localparam int CW = count_width(W);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(chunk_bits[i]);
        end
    end

endmodule

// File: rtl/slice_fault_scan_ctrl.sv
// Two-pattern stuck-at scan sequencer for one MAC slice, producing SA0/SA1 cell maps.
// Define SLICE_SCAN_FAULT_COUNT_EN to build the chunked fault counter (COUNT state).
module slice_fault_scan_ctrl
    import slice_scan_pkg::*;
#(
    parameter int N       = 256,
    parameter int MAC_LAT = 1,
    parameter int CHUNK   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N-1:0]              in_array,
    output logic [4*N-1:0]            weight_array,
    input  logic [4*N-1:0]            product_array,
    output logic                      busy,
    output logic                      done,
    output logic [N-1:0]              sa0_map,
    output logic [N-1:0]              sa1_map,
    output logic [count_width(N)-1:0] fault_count
);

    localparam int                CNT_W     = count_width(N);
    localparam int                WAIT_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAC_LAT - 1);

    scan_state_t       state;
    scan_state_t       next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic              count_last;
    logic              start_ok;
    logic [N-1:0]      ne_exp0;
    logic [N-1:0]      ne_exp1;
    logic [N-1:0]      in_d;
    logic [4*N-1:0]    weight_d;
    logic              busy_d;
    logic              done_d;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign start_ok  = (state == S_IDLE) && start;

    always_comb begin
        ne_exp0 = '0;
        ne_exp1 = '0;
        for (int i = 0; i < N; i++) begin
            ne_exp0[i] = (product_array[4*i +: 4] != EXP0);
            ne_exp1[i] = (product_array[4*i +: 4] != EXP1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_P0;
            S_P0:    if (wait_last) next_state = S_C0;
            S_C0:    next_state = S_P1;
            S_P1:    if (wait_last) next_state = S_C1;
`ifdef SLICE_SCAN_FAULT_COUNT_EN
            S_C1:    next_state = S_COUNT;
`else
            S_C1:    next_state = S_DONE;
`endif
            S_COUNT: if (count_last) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output values are computed for the state being entered so the registers change on that edge.
    always_comb begin
        in_d     = '0;
        weight_d = '0;
        busy_d   = (next_state != S_IDLE);
        done_d   = (state == S_DONE);
        case (next_state)
            S_P0, S_C0: begin
                in_d     = '1;
                weight_d = {N{P0_WEIGHT}};
            end
            S_P1, S_C1: begin
                in_d     = '1;
                weight_d = {N{P1_WEIGHT}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_array     <= '0;
            weight_array <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            in_array     <= in_d;
            weight_array <= weight_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state == S_P0) || (state == S_P1)) begin
            wait_cnt <= wait_last ? '0 : wait_cnt + WAIT_W'(1);
        end
    end

    // SA1 wins over SA0, so a cell mismatching in both phases lands only in the SA1 map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa0_map <= '0;
            sa1_map <= '0;
        end else if (start_ok) begin
            sa0_map <= '0;
            sa1_map <= '0;
        end else if (state == S_C0) begin
            sa1_map <= ne_exp0;
        end else if (state == S_C1) begin
            sa0_map <= ne_exp1 & ~sa1_map;
        end
    end

`ifdef SLICE_SCAN_FAULT_COUNT_EN
    localparam int NUM_CHUNKS = N / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int PC_W       = count_width(CHUNK);

    logic [IDX_W-1:0] chunk_idx;
    logic [N-1:0]     fault_vec;
    logic [CHUNK-1:0] chunk_sel;
    logic [PC_W-1:0]  chunk_pop;
    logic [CNT_W-1:0] fault_count_q;

    assign fault_vec  = sa0_map | sa1_map;
    assign chunk_sel  = fault_vec[int'(chunk_idx)*CHUNK +: CHUNK];
    assign count_last = (chunk_idx == IDX_W'(NUM_CHUNKS - 1));

    slice_popcount_chunk #(
        .W(CHUNK)
    ) u_popcount (
        .chunk_bits(chunk_sel),
        .count     (chunk_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_idx     <= '0;
            fault_count_q <= '0;
        end else if (start_ok) begin
            chunk_idx     <= '0;
            fault_count_q <= '0;
        end else if (state == S_COUNT) begin
            chunk_idx     <= count_last ? '0 : chunk_idx + IDX_W'(1);
            fault_count_q <= fault_count_q + CNT_W'(chunk_pop);
        end
    end

    assign fault_count = fault_count_q;
`else
    logic [31:0] unused_chunk;

    assign unused_chunk = CHUNK;
    assign count_last   = 1'b1;
    assign fault_count  = '0;
`endif

endmodule

// File: tb/tb_slice_fault_scan_ctrl.sv
// Self-checking bench for slice_fault_scan_ctrl with a behavioural faulty-slice model.
module tb_slice_fault_scan_ctrl;

    localparam int N       = 256;
    localparam int MAC_LAT = 1;
    localparam int CHUNK   = 16;
    localparam int CW      = $clog2(N + 1);
`ifdef SLICE_SCAN_FAULT_COUNT_EN
    localparam int EXP_DONE  = 2*MAC_LAT + 3 + N/CHUNK;
    localparam int RST_EDGE  = 2*MAC_LAT + 8;
    localparam bit COUNT_ON  = 1'b1;
`else
    localparam int EXP_DONE  = 2*MAC_LAT + 3;
    localparam int RST_EDGE  = MAC_LAT + 2;
    localparam bit COUNT_ON  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N-1:0]    in_array;
    logic [4*N-1:0]  weight_array;
    logic [4*N-1:0]  product_array;
    logic            busy;
    logic            done;
    logic [N-1:0]    sa0_map;
    logic [N-1:0]    sa1_map;
    logic [CW-1:0]   fault_count;

    logic [N-1:0]    sa0_cells;
    logic [N-1:0]    sa1_cells;

    int tests_run    = 0;
    int tests_failed = 0;

    int             lat;
    int             lat2;
    int             pulses;
    logic [63:0]    busy_hist;
    logic [N-1:0]   in_at0;
    logic [N-1:0]   in_at_end;
    logic [4*N-1:0] w_at0;
    logic [4*N-1:0] w_at2;
    logic [4*N-1:0] w_at_end;
    logic           maps_at0;

    always #5 clk = ~clk;

    slice_fault_scan_ctrl #(
        .N(N), .MAC_LAT(MAC_LAT), .CHUNK(CHUNK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_array(in_array), .weight_array(weight_array), .product_array(product_array),
        .busy(busy), .done(done), .sa0_map(sa0_map), .sa1_map(sa1_map), .fault_count(fault_count)
    );

    // A stuck-at-1 cell forces its product LSB high, a stuck-at-0 cell forces its MSB low.
    function automatic logic [3:0] slice_nibble(input logic a, input logic [3:0] w, input logic s0, input logic s1);
        logic [3:0] r;
        r = a ? w : 4'h0;
        if (s1) r[0] = 1'b1;
        if (s0) r[3] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            product_array[4*i +: 4] <= slice_nibble(in_array[i], weight_array[4*i +: 4], sa0_cells[i], sa1_cells[i]);
    end

    task automatic model_scan(input logic [N-1:0] s0, input logic [N-1:0] s1,
                              output logic [N-1:0] e0, output logic [N-1:0] e1, output int cnt);
        logic [3:0] p0, p1;
        e0 = '0; e1 = '0; cnt = 0;
        for (int i = 0; i < N; i++) begin
            p0 = slice_nibble(1'b1, 4'h0, s0[i], s1[i]);
            p1 = slice_nibble(1'b1, 4'hF, s0[i], s1[i]);
            e1[i] = (p0 != 4'h0);
            e0[i] = (p1 != 4'hF) && !e1[i];
            if (e0[i] || e1[i]) cnt++;
        end
        if (!COUNT_ON) cnt = 0;
    endtask

    task automatic run_scan(input int s1, input int s2);
        lat = -1; lat2 = -1; pulses = 0; busy_hist = '0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        busy_hist[0] = busy; in_at0 = in_array; w_at0 = weight_array; maps_at0 = |(sa0_map | sa1_map);
        for (int k = 1; k < 64; k++) begin
            @(posedge clk); #1;
            busy_hist[k] = busy;
            if (k == MAC_LAT + 1) w_at2 = weight_array;
            if (k == 2*MAC_LAT + 2) begin w_at_end = weight_array; in_at_end = in_array; end
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k; else if (lat2 < 0) lat2 = k;
            end
            start = ((k + 1) == s1) || ((k + 1) == s2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sa0_cells = '0; sa1_cells = '0;
        repeat (2) @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (in_array !== '0) begin tests_failed++; $display("[TB] FAIL reset_in: got %h expected 0", in_array); end
        tests_run++; if (weight_array !== '0) begin tests_failed++; $display("[TB] FAIL reset_weight: got %h expected 0", weight_array); end
        tests_run++; if ((sa0_map | sa1_map) !== '0) begin tests_failed++; $display("[TB] FAIL reset_maps: got sa0 %h sa1 %h expected 0", sa0_map, sa1_map); end
        tests_run++; if (fault_count !== '0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", fault_count); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_no_fault();
        logic [N-1:0] e0, e1; int cnt;
        sa0_cells = '0; sa1_cells = '0;
        model_scan(sa0_cells, sa1_cells, e0, e1, cnt);
        run_scan(0, 0);
        tests_run++; if (lat !== EXP_DONE) begin tests_failed++; $display("[TB] FAIL nofault_done_edge: got %0d expected %0d", lat, EXP_DONE); end
        tests_run++; if (pulses !== 1) begin tests_failed++; $display("[TB] FAIL nofault_pulses: got %0d expected 1", pulses); end
        tests_run++; if (sa0_map !== e0 || sa1_map !== e1) begin tests_failed++; $display("[TB] FAIL nofault_maps: got sa0 %h sa1 %h expected 0", sa0_map, sa1_map); end
        tests_run++; if (fault_count !== CW'(cnt)) begin tests_failed++; $display("[TB] FAIL nofault_count: got %0d expected %0d", fault_count, cnt); end
        tests_run++; if (busy_hist[0] !== 1'b1 || busy_hist[EXP_DONE-1] !== 1'b1 || busy_hist[EXP_DONE+1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL nofault_busy: got start %b last %b after %b expected 1 1 0", busy_hist[0], busy_hist[EXP_DONE-1], busy_hist[EXP_DONE+1]); end
        tests_run++; if (in_at0 !== {N{1'b1}} || w_at0 !== '0) begin tests_failed++; $display("[TB] FAIL phase0_pattern: got in %h weight %h expected in all 1s weight 0", in_at0, w_at0); end
        tests_run++; if (w_at2 !== {(4*N){1'b1}}) begin tests_failed++; $display("[TB] FAIL phase1_pattern: got weight %h expected all F", w_at2); end
        tests_run++; if (w_at_end !== '0 || in_at_end !== '0) begin tests_failed++; $display("[TB] FAIL pattern_release: got in %h weight %h expected 0", in_at_end, w_at_end); end
    endtask

    task automatic test_two_faults();
        logic [N-1:0] exp0, exp1;
        sa0_cells = '0; sa1_cells = '0; sa1_cells[3] = 1'b1; sa0_cells[200] = 1'b1;
        exp0 = '0; exp0[200] = 1'b1; exp1 = '0; exp1[3] = 1'b1;
        run_scan(0, 0);
        tests_run++; if (sa1_map !== exp1) begin tests_failed++; $display("[TB] FAIL two_sa1: got %h expected %h", sa1_map, exp1); end
        tests_run++; if (sa0_map !== exp0) begin tests_failed++; $display("[TB] FAIL two_sa0: got %h expected %h", sa0_map, exp0); end
        tests_run++; if (fault_count !== CW'(COUNT_ON ? 2 : 0)) begin tests_failed++; $display("[TB] FAIL two_count: got %0d expected %0d", fault_count, COUNT_ON ? 2 : 0); end
    endtask

    task automatic test_both_faults();
        logic [N-1:0] exp1;
        sa0_cells = '0; sa1_cells = '0; sa0_cells[7] = 1'b1; sa1_cells[7] = 1'b1;
        exp1 = '0; exp1[7] = 1'b1;
        run_scan(0, 0);
        tests_run++; if (sa1_map !== exp1) begin tests_failed++; $display("[TB] FAIL both_sa1: got %h expected %h", sa1_map, exp1); end
        tests_run++; if (sa0_map !== '0) begin tests_failed++; $display("[TB] FAIL both_sa0: got %h expected 0", sa0_map); end
        tests_run++; if (fault_count !== CW'(COUNT_ON ? 1 : 0)) begin tests_failed++; $display("[TB] FAIL both_count: got %0d expected %0d", fault_count, COUNT_ON ? 1 : 0); end
    endtask

    task automatic test_all_sa0();
        sa0_cells = '1; sa1_cells = '0;
        run_scan(0, 0);
        tests_run++; if (sa0_map !== {N{1'b1}} || sa1_map !== '0) begin tests_failed++; $display("[TB] FAIL allsa0_maps: got sa0 %h sa1 %h expected all 1s and 0", sa0_map, sa1_map); end
        tests_run++; if (fault_count !== CW'(COUNT_ON ? N : 0)) begin tests_failed++; $display("[TB] FAIL allsa0_count: got %0d expected %0d", fault_count, COUNT_ON ? N : 0); end
    endtask

    task automatic test_random();
        logic [N-1:0] e0, e1; int cnt;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) begin
                sa0_cells[i] = ($urandom_range(0, 7) == 0);
                sa1_cells[i] = ($urandom_range(0, 9) == 0);
            end
            model_scan(sa0_cells, sa1_cells, e0, e1, cnt);
            run_scan(0, 0);
            tests_run++; if (sa0_map !== e0 || sa1_map !== e1) begin tests_failed++; $display("[TB] FAIL random_maps[%0d]: got sa0 %h sa1 %h expected sa0 %h sa1 %h", it, sa0_map, sa1_map, e0, e1); end
            tests_run++; if (fault_count !== CW'(cnt)) begin tests_failed++; $display("[TB] FAIL random_count[%0d]: got %0d expected %0d", it, fault_count, cnt); end
            tests_run++; if (lat !== EXP_DONE) begin tests_failed++; $display("[TB] FAIL random_done_edge[%0d]: got %0d expected %0d", it, lat, EXP_DONE); end
        end
    endtask

    task automatic test_start_ignored();
        logic [N-1:0] e0, e1; int cnt;
        sa0_cells = '0; sa1_cells = '0; sa0_cells[17] = 1'b1; sa1_cells[90] = 1'b1;
        model_scan(sa0_cells, sa1_cells, e0, e1, cnt);
        run_scan(MAC_LAT + 2, EXP_DONE);
        tests_run++; if (pulses !== 1 || lat !== EXP_DONE) begin tests_failed++; $display("[TB] FAIL ignored_done: got %0d pulses first at %0d expected 1 at %0d", pulses, lat, EXP_DONE); end
        tests_run++; if (busy_hist[EXP_DONE+2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL ignored_busy: got %b expected 0", busy_hist[EXP_DONE+2]); end
        tests_run++; if (sa0_map !== e0 || sa1_map !== e1) begin tests_failed++; $display("[TB] FAIL ignored_maps: got sa0 %h sa1 %h expected sa0 %h sa1 %h", sa0_map, sa1_map, e0, e1); end
    endtask

    task automatic test_restart_clears();
        sa0_cells = '0; sa1_cells = '0;
        run_scan(0, 0);
        tests_run++; if (maps_at0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_clear: got maps nonzero after start expected 0"); end
        tests_run++; if ((sa0_map | sa1_map) !== '0) begin tests_failed++; $display("[TB] FAIL restart_maps: got sa0 %h sa1 %h expected 0", sa0_map, sa1_map); end
    endtask

    task automatic test_back_to_back();
        sa0_cells = '0; sa1_cells = '0; sa1_cells[250] = 1'b1;
        run_scan(EXP_DONE + 1, 0);
        tests_run++; if (pulses !== 2 || lat2 !== 2*EXP_DONE + 1) begin tests_failed++; $display("[TB] FAIL b2b_done: got %0d pulses second at %0d expected 2 at %0d", pulses, lat2, 2*EXP_DONE + 1); end
        tests_run++; if (busy_hist[EXP_DONE+1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_accept: got busy %b expected 1", busy_hist[EXP_DONE+1]); end
    endtask

    task automatic test_reset_mid_scan();
        logic [N-1:0] e0, e1; int cnt; int done_seen;
        sa0_cells = '0; sa1_cells = '0; sa1_cells[5] = 1'b1; sa0_cells[100] = 1'b1; sa0_cells[250] = 1'b1;
        done_seen = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (RST_EDGE) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_flags: got busy %b done %b expected 0 0", busy, done); end
        tests_run++; if ((sa0_map | sa1_map) !== '0) begin tests_failed++; $display("[TB] FAIL abort_maps: got sa0 %h sa1 %h expected 0", sa0_map, sa1_map); end
        tests_run++; if (fault_count !== '0 || in_array !== '0 || weight_array !== '0) begin tests_failed++; $display("[TB] FAIL abort_outputs: got count %0d in %h expected 0", fault_count, in_array); end
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) done_seen++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done === 1'b1) done_seen++; end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
        model_scan(sa0_cells, sa1_cells, e0, e1, cnt);
        run_scan(0, 0);
        tests_run++; if (lat !== EXP_DONE) begin tests_failed++; $display("[TB] FAIL rerun_done_edge: got %0d expected %0d", lat, EXP_DONE); end
        tests_run++; if (sa0_map !== e0 || sa1_map !== e1 || fault_count !== CW'(cnt)) begin tests_failed++; $display("[TB] FAIL rerun_result: got sa0 %h sa1 %h count %0d expected count %0d", sa0_map, sa1_map, fault_count, cnt); end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_no_fault();
        test_two_faults();
        test_both_faults();
        test_all_sa0();
        test_random();
        test_start_ignored();
        test_restart_clears();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
